dual_issue_imm_scheduler: RTL and testbench

- Pair-issue controller between decode and the two-lane immediate extender / execute stage of the 2-wide core.
- Buffers one decoded instruction pair and checks intra-pair RAW, memory-port and control-flow hazards.
- Issues the pair together or splits it over two cycles, and drives per-lane extender enable, type, op_code and raw immediate.
- Counts split events for performance monitoring.

---
 rtl/dual_issue_imm_scheduler_pkg.sv | 46 ++++
 rtl/dual_issue_imm_scheduler_if.sv | 42 ++++
 rtl/dual_issue_imm_scheduler_pair_hazard_check.sv | 26 ++
 rtl/dual_issue_imm_scheduler.sv | 143 ++++++++++++++
 tb/tb_dual_issue_imm_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_imm_scheduler_pkg.sv
// Shared definitions for the dual-issue immediate scheduler: opcode constants,
// FSM state encoding, the decoded slot record and opcode classification helpers.
package dual_issue_imm_scheduler_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HOLD1 = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] op_code;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
    } issue_slot_t;

    // Opcodes whose immediate goes through the extender (U-type covered by xx101).
    function automatic logic ext_op_sel(input logic [4:0] op);
        ext_op_sel = (op[2:0] == 3'b101) || (op == OP_IMM) || (op == OP_LOAD) ||
                     (op == OP_STORE) || ((op[4:2] == 3'b110) && op[0]) ||
                     (op == OP_BRANCH);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        is_mem_op = (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctl_op(input logic [4:0] op);
        is_ctl_op = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/dual_issue_imm_scheduler_if.sv
// Decode / execute side bundle of the pair scheduler; master = decode+execute, slave = scheduler.
interface dual_issue_imm_scheduler_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic                 flush;
    logic                 dec_valid;
    logic                 dec_ready;
    logic [1:0]           dec_slot_valid;
    logic [1:0][4:0]      dec_op_code;
    logic [1:0][XLEN-1:0] dec_imm_raw;
    logic [1:0]           dec_imm_unsigned;
    logic [1:0][4:0]      dec_rd;
    logic [1:0][4:0]      dec_rs1;
    logic [1:0][4:0]      dec_rs2;
    logic [1:0]           dec_uses_rs1;
    logic [1:0]           dec_uses_rs2;
    logic [1:0]           dec_writes_rd;
    logic                 ex_ready;
    logic [1:0]           iss_valid;
    logic [1:0]           ext_en;
    logic [1:0]           ext_type;
    logic [1:0][4:0]      ext_op_code;
    logic [1:0][XLEN-1:0] ext_imm_in;
    logic [CNT_W-1:0]     split_count;

    modport master (
        output flush, dec_valid, dec_slot_valid, dec_op_code, dec_imm_raw,
               dec_imm_unsigned, dec_rd, dec_rs1, dec_rs2, dec_uses_rs1,
               dec_uses_rs2, dec_writes_rd, ex_ready,
        input  dec_ready, iss_valid, ext_en, ext_type, ext_op_code, ext_imm_in,
               split_count
    );

    modport slave (
        input  flush, dec_valid, dec_slot_valid, dec_op_code, dec_imm_raw,
               dec_imm_unsigned, dec_rd, dec_rs1, dec_rs2, dec_uses_rs1,
               dec_uses_rs2, dec_writes_rd, ex_ready,
        output dec_ready, iss_valid, ext_en, ext_type, ext_op_code, ext_imm_in,
               split_count
    );
endinterface

// File: rtl/dual_issue_imm_scheduler_pair_hazard_check.sv
// Combinational split decision for an instruction pair: intra-pair RAW,
// dual memory access, or control flow in the older slot.
module pair_hazard_check
    import dual_issue_imm_scheduler_pkg::*;
(
    input  issue_slot_t s0_i,
    input  issue_slot_t s1_i,
    output logic        split_o
);
    logic raw_s;
    logic mem_s;
    logic ctl_s;
    logic unused_fields_s;

    assign raw_s = s0_i.writes_rd && (s0_i.rd != 5'd0) &&
                   ((s1_i.uses_rs1 && (s1_i.rs1 == s0_i.rd)) ||
                    (s1_i.uses_rs2 && (s1_i.rs2 == s0_i.rd)));
    assign mem_s = is_mem_op(s0_i.op_code) && is_mem_op(s1_i.op_code);
    assign ctl_s = is_ctl_op(s0_i.op_code);

    // A lone instruction never needs splitting.
    assign split_o = s0_i.valid && s1_i.valid && (raw_s || mem_s || ctl_s);

    assign unused_fields_s = ^{s0_i.rs1, s0_i.rs2, s0_i.uses_rs1, s0_i.uses_rs2,
                               s1_i.rd, s1_i.writes_rd};
endmodule

// File: rtl/dual_issue_imm_scheduler.sv
// Pair-issue controller: buffers one decoded pair, issues it whole or split over
// two cycles, and drives the per-lane immediate extender from registered outputs.
module dual_issue_imm_scheduler
    import dual_issue_imm_scheduler_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    dual_issue_imm_scheduler_if.slave   bus
);
    sched_state_e         state_q, state_d;
    logic                 split_q, split_d;
    logic [1:0][4:0]      op_q, op_d;
    logic [1:0]           uns_q, uns_d;
    logic [1:0][XLEN-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           iss_valid_q, iss_valid_d;
    logic [1:0]           ext_en_q, ext_en_d;
    logic [1:0]           ext_type_q, ext_type_d;
    logic [1:0][4:0]      ext_op_q, ext_op_d;
    logic [1:0][XLEN-1:0] ext_imm_q, ext_imm_d;

    issue_slot_t dec_slot_s [2];
    logic        hazard_s;
    logic        done_s;
    logic        dec_ready_s;
    logic        accept_s;

    // Pack the decode-side slot fields for the hazard checker.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dec_slot_s[i].valid     = bus.dec_slot_valid[i];
            dec_slot_s[i].op_code   = bus.dec_op_code[i];
            dec_slot_s[i].rd        = bus.dec_rd[i];
            dec_slot_s[i].rs1       = bus.dec_rs1[i];
            dec_slot_s[i].rs2       = bus.dec_rs2[i];
            dec_slot_s[i].uses_rs1  = bus.dec_uses_rs1[i];
            dec_slot_s[i].uses_rs2  = bus.dec_uses_rs2[i];
            dec_slot_s[i].writes_rd = bus.dec_writes_rd[i];
        end
    end

    // Hazards are judged on the incoming pair so the first issue cycle is already registered.
    pair_hazard_check u_hazard (
        .s0_i    (dec_slot_s[0]),
        .s1_i    (dec_slot_s[1]),
        .split_o (hazard_s)
    );

    assign done_s      = bus.ex_ready && (((state_q == ST_FULL) && !split_q) ||
                                          (state_q == ST_HOLD1));
    assign dec_ready_s = (state_q == ST_EMPTY) || done_s;
    assign accept_s    = bus.dec_valid && dec_ready_s && !bus.flush;

    // Next-state, buffer and issue-vector selection; flush outranks everything.
    always_comb begin
        state_d     = state_q;
        split_d     = split_q;
        op_d        = op_q;
        uns_d       = uns_q;
        imm_d       = imm_q;
        cnt_d       = cnt_q;
        iss_valid_d = iss_valid_q;
        if (bus.flush) begin
            state_d     = ST_EMPTY;
            split_d     = 1'b0;
            iss_valid_d = 2'b00;
        end else if (bus.ex_ready && (state_q == ST_FULL) && split_q) begin
            state_d     = ST_HOLD1;
            split_d     = 1'b0;
            iss_valid_d = 2'b10;
            cnt_d       = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (accept_s && (|bus.dec_slot_valid)) begin
            state_d     = ST_FULL;
            split_d     = hazard_s;
            op_d        = bus.dec_op_code;
            uns_d       = bus.dec_imm_unsigned;
            imm_d       = bus.dec_imm_raw;
            iss_valid_d = hazard_s ? 2'b01 : bus.dec_slot_valid;
        end else if (done_s) begin
            state_d     = ST_EMPTY;
            split_d     = 1'b0;
            iss_valid_d = 2'b00;
        end else begin
            state_d     = state_q;
        end
    end

    // Extender drive follows the next issue vector; idle lanes are forced to zero.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ext_en_d[i] = iss_valid_d[i] && ext_op_sel(op_d[i]);
            if (ext_en_d[i]) begin
                ext_type_d[i] = uns_d[i];
                ext_op_d[i]   = op_d[i];
                ext_imm_d[i]  = imm_d[i];
            end else begin
                ext_type_d[i] = 1'b0;
                ext_op_d[i]   = 5'd0;
                ext_imm_d[i]  = {XLEN{1'b0}};
            end
        end
    end

    // Scheduler state and registered outputs; split_count survives flush but not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            split_q     <= 1'b0;
            op_q        <= '0;
            uns_q       <= 2'b00;
            imm_q       <= '0;
            cnt_q       <= {CNT_W{1'b0}};
            iss_valid_q <= 2'b00;
            ext_en_q    <= 2'b00;
            ext_type_q  <= 2'b00;
            ext_op_q    <= '0;
            ext_imm_q   <= '0;
        end else begin
            state_q     <= state_d;
            split_q     <= split_d;
            op_q        <= op_d;
            uns_q       <= uns_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
            iss_valid_q <= iss_valid_d;
            ext_en_q    <= ext_en_d;
            ext_type_q  <= ext_type_d;
            ext_op_q    <= ext_op_d;
            ext_imm_q   <= ext_imm_d;
        end
    end

    assign bus.dec_ready   = dec_ready_s;
    assign bus.iss_valid   = iss_valid_q;
    assign bus.ext_en      = ext_en_q;
    assign bus.ext_type    = ext_type_q;
    assign bus.ext_op_code = ext_op_q;
    assign bus.ext_imm_in  = ext_imm_q;
    assign bus.split_count = cnt_q;
endmodule

// File: tb/tb_dual_issue_imm_scheduler.sv
// Directed bench for dual_issue_imm_scheduler; expected values are hand-computed.
module tb_dual_issue_imm_scheduler;
    import dual_issue_imm_scheduler_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    dual_issue_imm_scheduler_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    dual_issue_imm_scheduler #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_dec();
        bus.dec_valid        = 1'b0;
        bus.dec_slot_valid   = 2'b00;
        bus.dec_op_code      = '0;
        bus.dec_imm_raw      = '0;
        bus.dec_imm_unsigned = 2'b00;
        bus.dec_rd           = '0;
        bus.dec_rs1          = '0;
        bus.dec_rs2          = '0;
        bus.dec_uses_rs1     = 2'b00;
        bus.dec_uses_rs2     = 2'b00;
        bus.dec_writes_rd    = 2'b00;
    endtask

    // flags = {writes_rd, uses_rs2, uses_rs1}
    task automatic set_slot(input int s, input logic [4:0] op, input logic [31:0] imm,
                            input logic uns, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] flags);
        bus.dec_slot_valid[s]   = 1'b1;
        bus.dec_op_code[s]      = op;
        bus.dec_imm_raw[s]      = imm;
        bus.dec_imm_unsigned[s] = uns;
        bus.dec_rd[s]           = rd;
        bus.dec_rs1[s]          = rs1;
        bus.dec_rs2[s]          = rs2;
        bus.dec_uses_rs1[s]     = flags[0];
        bus.dec_uses_rs2[s]     = flags[1];
        bus.dec_writes_rd[s]    = flags[2];
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        clear_dec();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_iss", bus.iss_valid, 2'b00);
        chk("rst_en", bus.ext_en, 2'b00);
        chk("rst_type", bus.ext_type, 2'b00);
        chk("rst_imm0", bus.ext_imm_in[0], 32'h0);
        chk("rst_cnt", bus.split_count, 5'd0);
        chk("rst_ready", bus.dec_ready, 1'b1);

        // Independent addi pair
        bus.ex_ready = 1'b1;
        set_slot(0, OP_IMM, 32'h0000_0FFF, 1'b0, 5'd1, 5'd0, 5'd0, 3'b101);
        set_slot(1, OP_IMM, 32'h0000_0123, 1'b0, 5'd2, 5'd0, 5'd0, 3'b101);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("ind_iss", bus.iss_valid, 2'b11);
        chk("ind_en", bus.ext_en, 2'b11);
        chk("ind_type", bus.ext_type, 2'b00);
        chk("ind_imm0", bus.ext_imm_in[0], 32'h0000_0FFF);
        chk("ind_op1", bus.ext_op_code[1], OP_IMM);
        chk("ind_cnt", bus.split_count, 5'd0);
        tick();
        chk("ind_drain", bus.iss_valid, 2'b00);

        // RAW through x5
        set_slot(0, OP_IMM, 32'h0000_0010, 1'b0, 5'd5, 5'd0, 5'd0, 3'b101);
        set_slot(1, OP_IMM, 32'h0000_0020, 1'b0, 5'd6, 5'd5, 5'd0, 3'b101);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("raw_c1_iss", bus.iss_valid, 2'b01);
        chk("raw_c1_en", bus.ext_en, 2'b01);
        chk("raw_c1_ready", bus.dec_ready, 1'b0);
        tick();
        chk("raw_c2_iss", bus.iss_valid, 2'b10);
        chk("raw_c2_imm1", bus.ext_imm_in[1], 32'h0000_0020);
        chk("raw_c2_imm0", bus.ext_imm_in[0], 32'h0);
        chk("raw_cnt", bus.split_count, 5'd1);
        chk("raw_c2_ready", bus.dec_ready, 1'b1);
        tick();
        chk("raw_drain", bus.iss_valid, 2'b00);

        // Same shape through x0 does not split
        set_slot(0, OP_IMM, 32'h0000_0010, 1'b0, 5'd0, 5'd0, 5'd0, 3'b101);
        set_slot(1, OP_IMM, 32'h0000_0020, 1'b0, 5'd6, 5'd0, 5'd0, 3'b101);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("x0_iss", bus.iss_valid, 2'b11);
        chk("x0_cnt", bus.split_count, 5'd1);
        tick();

        // Load + store, then stall in HOLD1
        set_slot(0, OP_LOAD, 32'h0000_0004, 1'b0, 5'd6, 5'd1, 5'd0, 3'b101);
        set_slot(1, OP_STORE, 32'hFFFF_FFF8, 1'b0, 5'd0, 5'd7, 5'd8, 3'b011);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("mem_c1_iss", bus.iss_valid, 2'b01);
        tick();
        chk("mem_c2_iss", bus.iss_valid, 2'b10);
        chk("mem_cnt", bus.split_count, 5'd2);
        bus.ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mem_stall_iss", bus.iss_valid, 2'b10);
            chk("mem_stall_op1", bus.ext_op_code[1], OP_STORE);
            chk("mem_stall_imm1", bus.ext_imm_in[1], 32'hFFFF_FFF8);
            chk("mem_stall_ready", bus.dec_ready, 1'b0);
        end
        chk("mem_stall_cnt", bus.split_count, 5'd2);
        bus.ex_ready = 1'b1;
        tick();
        chk("mem_drain", bus.iss_valid, 2'b00);

        // Branch in slot0, then flush in HOLD1
        set_slot(0, OP_BRANCH, 32'h0000_0800, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011);
        set_slot(1, OP_IMM, 32'h0000_0055, 1'b0, 5'd3, 5'd0, 5'd0, 3'b101);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("br_c1_iss", bus.iss_valid, 2'b01);
        chk("br_c1_en", bus.ext_en, 2'b01);
        tick();
        chk("br_c2_iss", bus.iss_valid, 2'b10);
        chk("br_cnt", bus.split_count, 5'd3);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_iss", bus.iss_valid, 2'b00);
        chk("fl_en", bus.ext_en, 2'b00);
        chk("fl_ready", bus.dec_ready, 1'b1);
        chk("fl_cnt", bus.split_count, 5'd3);
        tick();
        chk("fl_after_iss", bus.iss_valid, 2'b00);

        // Slot1 only, opcode without extender use
        set_slot(1, 5'b01100, 32'h0000_ABCD, 1'b0, 5'd4, 5'd1, 5'd2, 3'b111);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("s1_iss", bus.iss_valid, 2'b10);
        chk("s1_en", bus.ext_en, 2'b00);
        chk("s1_imm1", bus.ext_imm_in[1], 32'h0);
        tick();

        // Slot0-only lui with zero-extension
        set_slot(0, OP_LUI, 32'h000A_BCDE, 1'b1, 5'd9, 5'd0, 5'd0, 3'b100);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("lui_iss", bus.iss_valid, 2'b01);
        chk("lui_en", bus.ext_en, 2'b01);
        chk("lui_type", bus.ext_type, 2'b01);
        chk("lui_imm0", bus.ext_imm_in[0], 32'h000A_BCDE);
        tick();

        // Empty pair is dropped
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        chk("nil_iss", bus.iss_valid, 2'b00);
        chk("nil_ready", bus.dec_ready, 1'b1);

        // Back-to-back independent pairs
        for (int k = 0; k < 4; k++) begin
            set_slot(0, OP_IMM, 32'h100 + k, 1'b0, 5'd1, 5'd0, 5'd0, 3'b101);
            set_slot(1, OP_IMM, 32'h200 + k, 1'b0, 5'd2, 5'd0, 5'd0, 3'b101);
            bus.dec_valid = 1'b1;
            chk("b2b_ready", bus.dec_ready, 1'b1);
            tick();
            chk("b2b_iss", bus.iss_valid, 2'b11);
            chk("b2b_imm0", bus.ext_imm_in[0], 64'h100 + k);
        end
        clear_dec();
        tick();
        chk("b2b_drain", bus.iss_valid, 2'b00);

        // Forced load+load splits: one split every two cycles
        set_slot(0, OP_LOAD, 32'h0, 1'b0, 5'd1, 5'd2, 5'd0, 3'b101);
        set_slot(1, OP_LOAD, 32'h4, 1'b0, 5'd3, 5'd4, 5'd0, 3'b101);
        bus.dec_valid = 1'b1;
        for (int k = 0; k < 54; k++) tick();
        chk("sat_pre", bus.split_count, 5'd30);
        for (int k = 0; k < 6; k++) tick();
        clear_dec();
        tick();
        tick();
        chk("sat_cnt", bus.split_count, 5'h1F);
        chk("sat_iss", bus.iss_valid, 2'b00);

        // Reset while slot1 is held
        set_slot(0, OP_LOAD, 32'h8, 1'b0, 5'd1, 5'd2, 5'd0, 3'b101);
        set_slot(1, OP_STORE, 32'hC, 1'b0, 5'd0, 5'd3, 5'd4, 3'b011);
        bus.dec_valid = 1'b1;
        tick();
        clear_dec();
        tick();
        chk("rh_iss", bus.iss_valid, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_iss0", bus.iss_valid, 2'b00);
        chk("rh_en", bus.ext_en, 2'b00);
        chk("rh_type", bus.ext_type, 2'b00);
        chk("rh_op1", bus.ext_op_code[1], 5'd0);
        chk("rh_imm1", bus.ext_imm_in[1], 32'h0);
        chk("rh_cnt", bus.split_count, 5'd0);
        chk("rh_ready", bus.dec_ready, 1'b1);
        tick();
        chk("rh_after_iss", bus.iss_valid, 2'b00);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
